// File: rtl/hazard_scoreboard_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall/flush controller: ID instruction
// attributes and global events in, stage stall/flush and PC-select controls out.
interface hazard_scoreboard_ctrl_if;
   logic       exception;
   logic       mem_wait;
   logic       isbranch;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_read_rs;
   logic       id_read_rt;
   logic       id_branch_reg;
   logic       id_wr_en;
   logic [4:0] id_wr_dst;
   logic       id_is_load;
   logic       id_is_md;
   logic       id_md_div;
   logic       id_uses_hilo;
   logic       id_eret;

   logic       if_stall;
   logic       id_stall;
   logic       ex_stall;
   logic       mem_stall;
   logic       if_flush;
   logic       id_flush;
   logic       ex_flush;
   logic       mem_flush;
   logic       wb_flush;
   logic [1:0] pc_src;
   logic       md_busy;
   logic       id_issue;

   modport master (
      output exception, mem_wait, isbranch, id_valid, id_rs, id_rt,
             id_read_rs, id_read_rt, id_branch_reg, id_wr_en, id_wr_dst,
             id_is_load, id_is_md, id_md_div, id_uses_hilo, id_eret,
      input  if_stall, id_stall, ex_stall, mem_stall,
             if_flush, id_flush, ex_flush, mem_flush, wb_flush,
             pc_src, md_busy, id_issue
   );

   modport slave (
      input  exception, mem_wait, isbranch, id_valid, id_rs, id_rt,
             id_read_rs, id_read_rt, id_branch_reg, id_wr_en, id_wr_dst,
             id_is_load, id_is_md, id_md_div, id_uses_hilo, id_eret,
      output if_stall, id_stall, ex_stall, mem_stall,
             if_flush, id_flush, ex_flush, mem_flush, wb_flush,
             pc_src, md_busy, id_issue
   );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// 5-stage MIPS hazard controller: per-GPR ready countdown scoreboard, HI/LO-only
// mult/div busy interlock, data-SRAM wait freeze and exception/eret flushing.
module hazard_scoreboard_ctrl #(
   parameter int unsigned REG_NUM    = 32,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 33
) (
   input logic                     clk,
   input logic                     rst,
   hazard_scoreboard_ctrl_if.slave hz
);
   localparam int unsigned CW = $clog2(LOAD_LAT + 2);

   logic [CW-1:0] cnt_q [REG_NUM];
   logic [CW-1:0] cnt_d [REG_NUM];
   logic [5:0]    md_cnt_q;
   logic [5:0]    md_cnt_d;

   logic [CW-1:0] cnt_rs;
   logic [CW-1:0] cnt_rt;
   logic          rs_nz;
   logic          rt_nz;
   logic          raw_hz;
   logic          md_hz;
   logic          id_hz;
   logic          md_busy;
   logic          issue;

   assign cnt_rs = cnt_q[hz.id_rs];
   assign cnt_rt = cnt_q[hz.id_rt];
   assign rs_nz  = (hz.id_rs != '0);
   assign rt_nz  = (hz.id_rt != '0);

   // EX consumers can forward once the count is down to 1; ID-resolved branches need it at 0.
   assign raw_hz = hz.id_valid &
                   ((hz.id_read_rs & rs_nz & (cnt_rs > CW'(1))) |
                    (hz.id_read_rt & rt_nz & (cnt_rt > CW'(1))) |
                    (hz.id_branch_reg & ((rs_nz & (cnt_rs != '0)) | (rt_nz & (cnt_rt != '0)))));

   assign md_busy = ~rst & (md_cnt_q != '0);
   assign md_hz   = hz.id_valid & (hz.id_is_md | hz.id_uses_hilo) & md_busy;
   assign id_hz   = raw_hz | md_hz;
   assign issue   = hz.id_valid & ~rst & ~hz.exception & ~hz.mem_wait & ~id_hz;

   assign hz.id_issue = issue;
   assign hz.md_busy  = md_busy;

   always_comb begin
      hz.if_stall  = 1'b0;
      hz.id_stall  = 1'b0;
      hz.ex_stall  = 1'b0;
      hz.mem_stall = 1'b0;
      hz.if_flush  = 1'b0;
      hz.id_flush  = 1'b0;
      hz.ex_flush  = 1'b0;
      hz.mem_flush = 1'b0;
      hz.wb_flush  = 1'b0;
      hz.pc_src    = 2'd0;
      if (rst || hz.exception) begin
         hz.if_flush  = 1'b1;
         hz.id_flush  = 1'b1;
         hz.ex_flush  = 1'b1;
         hz.mem_flush = 1'b1;
         hz.wb_flush  = 1'b1;
         if (!rst) hz.pc_src = 2'd2;
      end else if (hz.mem_wait) begin
         hz.if_stall  = 1'b1;
         hz.id_stall  = 1'b1;
         hz.ex_stall  = 1'b1;
         hz.mem_stall = 1'b1;
      end else if (id_hz) begin
         hz.if_stall = 1'b1;
         hz.id_stall = 1'b1;
         hz.id_flush = 1'b1;
      end else if (hz.id_eret) begin
         hz.if_flush = 1'b1;
      end
      if (!rst && !hz.exception && !id_hz && hz.isbranch) hz.pc_src = 2'd1;
   end

   always_comb begin
      for (int unsigned i = 0; i < REG_NUM; i++) cnt_d[i] = cnt_q[i];
      if (hz.exception) begin
         for (int unsigned i = 0; i < REG_NUM; i++) cnt_d[i] = '0;
      end else if (!hz.mem_wait) begin
         for (int unsigned i = 1; i < REG_NUM; i++) begin
            if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
         end
         if (issue && hz.id_wr_en && (hz.id_wr_dst != '0)) begin
            cnt_d[hz.id_wr_dst] = hz.id_is_load ? CW'(LOAD_LAT + 1) : CW'(1);
         end
      end
      cnt_d[0] = '0;
   end

   // The mult/div unit keeps counting through mem_wait; only an exception aborts it.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (hz.exception) begin
         md_cnt_d = '0;
      end else if (issue && hz.id_is_md) begin
         md_cnt_d = hz.id_md_div ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '{default: '0};
         md_cnt_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         md_cnt_q <= md_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench: two controllers (LOAD_LAT 1 and 3) share stimulus; expected
// control vectors are queued per step and compared mid-cycle.
module tb_hazard_scoreboard_ctrl;
   logic clk;
   logic rst;
   logic exception, mem_wait, isbranch, id_valid;
   logic [4:0] id_rs, id_rt, id_wr_dst;
   logic id_read_rs, id_read_rt, id_branch_reg, id_wr_en, id_is_load;
   logic id_is_md, id_md_div, id_uses_hilo, id_eret;

   // {if_stall,id_stall,ex_stall,mem_stall, if..wb_flush, pc_src, md_busy, id_issue}
   logic [12:0] obs [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      hazard_scoreboard_ctrl_if bus ();
      assign bus.exception     = exception;
      assign bus.mem_wait      = mem_wait;
      assign bus.isbranch      = isbranch;
      assign bus.id_valid      = id_valid;
      assign bus.id_rs         = id_rs;
      assign bus.id_rt         = id_rt;
      assign bus.id_read_rs    = id_read_rs;
      assign bus.id_read_rt    = id_read_rt;
      assign bus.id_branch_reg = id_branch_reg;
      assign bus.id_wr_en      = id_wr_en;
      assign bus.id_wr_dst     = id_wr_dst;
      assign bus.id_is_load    = id_is_load;
      assign bus.id_is_md      = id_is_md;
      assign bus.id_md_div     = id_md_div;
      assign bus.id_uses_hilo  = id_uses_hilo;
      assign bus.id_eret       = id_eret;

      hazard_scoreboard_ctrl #(
         .REG_NUM    (32),
         .LOAD_LAT   ((g == 0) ? 1 : 3),
         .MUL_CYCLES (4),
         .DIV_CYCLES (33)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .hz  (bus)
      );

      assign obs[g] = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall,
                       bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush, bus.wb_flush,
                       bus.pc_src, bus.md_busy, bus.id_issue};
   end

   typedef struct {
      string       tag;
      int unsigned d;
      logic [12:0] e;
   } exp_t;

   exp_t        q[$];
   int unsigned n_assert;
   int unsigned n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] o(input logic [3:0] st, input logic [4:0] fl,
                                     input logic [1:0] pc, input logic busy, input logic iss);
      return {st, fl, pc, busy, iss};
   endfunction

   task automatic expect_both(input string tag, input logic [12:0] e1, input logic [12:0] e3);
      exp_t x;
      x.tag = tag; x.d = 0; x.e = e1; q.push_back(x);
      x.tag = tag; x.d = 1; x.e = e3; q.push_back(x);
   endtask

   task automatic expect_all(input string tag, input logic [12:0] e);
      expect_both(tag, e, e);
   endtask

   task automatic check_step();
      exp_t x;
      #3;
      while (q.size() > 0) begin
         x = q.pop_front();
         n_assert++;
         assert (obs[x.d] === x.e) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%b expected=%b", x.tag, x.d, obs[x.d], x.e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      exception = 0; mem_wait = 0; isbranch = 0; id_valid = 0;
      id_rs = 0; id_rt = 0; id_read_rs = 0; id_read_rt = 0; id_branch_reg = 0;
      id_wr_en = 0; id_wr_dst = 0; id_is_load = 0; id_is_md = 0; id_md_div = 0;
      id_uses_hilo = 0; id_eret = 0;
   endtask

   task automatic ins(input logic [4:0] rs, input logic [4:0] rt, input logic rrs, input logic rrt,
                      input logic wr, input logic [4:0] dst, input logic ld);
      nop();
      id_valid = 1; id_rs = rs; id_rt = rt; id_read_rs = rrs; id_read_rt = rrt;
      id_wr_en = wr; id_wr_dst = dst; id_is_load = ld;
   endtask

   task automatic idle(input int unsigned n);
      nop();
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [12:0] ISS, ISSB, STL, STLB, RST;

   initial begin
      n_assert = 0;
      n_fail   = 0;
      ISS  = o(4'b0000, 5'b00000, 2'd0, 1'b0, 1'b1);
      ISSB = o(4'b0000, 5'b00000, 2'd0, 1'b1, 1'b1);
      STL  = o(4'b1100, 5'b01000, 2'd0, 1'b0, 1'b0);
      STLB = o(4'b1100, 5'b01000, 2'd0, 1'b1, 1'b0);
      RST  = o(4'b0000, 5'b11111, 2'd0, 1'b0, 1'b0);

      // reset
      rst = 1;
      nop();
      id_valid = 1;
      @(posedge clk); #1;
      expect_all("reset", RST); check_step();
      rst = 0;

      // load-use: one stall at LOAD_LAT=1, three at LOAD_LAT=3
      ins(0, 0, 1, 0, 1, 5, 1); expect_all("lw_issue", ISS); check_step();
      ins(5, 0, 1, 1, 1, 6, 0); expect_all("ld_use_1", STL); check_step();
      expect_both("ld_use_2", ISS, STL); check_step();
      expect_both("ld_use_3", ISS, STL); check_step();
      expect_all("ld_use_4", ISS); check_step();
      ins(0, 0, 1, 0, 1, 5, 1); expect_all("lw_again", ISS); check_step();
      ins(7, 0, 1, 1, 1, 8, 0); expect_all("indep_issue", ISS); check_step();
      idle(4);

      // ALU result consumed by an ID-resolved branch
      ins(2, 3, 1, 1, 1, 4, 0); expect_all("addu4", ISS); check_step();
      ins(4, 0, 0, 0, 0, 0, 0); id_branch_reg = 1; isbranch = 1;
      expect_all("beq_stall", STL); check_step();
      expect_all("beq_taken", o(4'b0000, 5'b00000, 2'd1, 1'b0, 1'b1)); check_step();

      // div then independent adds, mflo waits out the divider
      ins(2, 3, 1, 1, 0, 0, 0); id_is_md = 1; id_md_div = 1;
      expect_all("div_issue", ISS); check_step();
      for (int i = 0; i < 5; i++) begin
         ins(2, 3, 1, 1, 1, 9, 0); expect_all("add_during_div", ISSB); check_step();
      end
      ins(0, 0, 0, 0, 1, 10, 0); id_uses_hilo = 1;
      for (int i = 0; i < 28; i++) begin
         expect_all("mflo_stall", STLB); check_step();
      end
      expect_all("mflo_issue", ISS); check_step();

      // mult busy window
      ins(2, 3, 1, 1, 0, 0, 0); id_is_md = 1;
      expect_all("mult_issue", ISS); check_step();
      ins(0, 0, 0, 0, 1, 11, 0); id_uses_hilo = 1;
      for (int i = 0; i < 4; i++) begin
         expect_all("mfhi_stall", STLB); check_step();
      end
      expect_all("mfhi_issue", ISS); check_step();
      idle(2);

      // mem_wait freezes the scoreboard but not the divider
      ins(2, 3, 1, 1, 0, 0, 0); id_is_md = 1; id_md_div = 1;
      expect_all("mw_div", ISS); check_step();
      ins(0, 0, 1, 0, 1, 5, 1); expect_all("mw_lw", ISSB); check_step();
      ins(5, 0, 1, 1, 1, 6, 0); mem_wait = 1;
      for (int i = 0; i < 4; i++) begin
         expect_all("mem_wait", o(4'b1111, 5'b00000, 2'd0, 1'b1, 1'b0)); check_step();
      end
      mem_wait = 0;
      expect_all("mw_use_1", STLB); check_step();
      expect_both("mw_use_2", ISSB, STLB); check_step();
      expect_both("mw_use_3", ISSB, STLB); check_step();
      expect_all("mw_use_4", ISSB); check_step();
      ins(0, 0, 0, 0, 1, 10, 0); id_uses_hilo = 1;
      for (int i = 0; i < 24; i++) begin
         expect_all("mw_mflo_stall", STLB); check_step();
      end
      expect_all("mw_mflo_issue", ISS); check_step();
      idle(2);

      // exception kills outstanding load and div
      ins(2, 3, 1, 1, 0, 0, 0); id_is_md = 1; id_md_div = 1;
      expect_all("ex_div", ISS); check_step();
      ins(0, 0, 1, 0, 1, 5, 1); expect_all("ex_lw", ISSB); check_step();
      ins(5, 0, 1, 1, 1, 6, 0); id_uses_hilo = 1; exception = 1; isbranch = 1;
      expect_all("exception", o(4'b0000, 5'b11111, 2'd2, 1'b1, 1'b0)); check_step();
      exception = 0; isbranch = 0;
      expect_all("post_exception", ISS); check_step();
      idle(2);

      // eret, and mem_wait over eret
      ins(0, 0, 0, 0, 0, 0, 0); id_eret = 1;
      expect_all("eret", o(4'b0000, 5'b10000, 2'd0, 1'b0, 1'b1)); check_step();
      mem_wait = 1;
      expect_all("eret_mem_wait", o(4'b1111, 5'b00000, 2'd0, 1'b0, 1'b0)); check_step();

      // register 0 never becomes busy
      ins(0, 0, 1, 0, 1, 0, 1); expect_all("lw_r0", ISS); check_step();
      ins(0, 0, 1, 1, 0, 0, 0); id_branch_reg = 1;
      expect_all("use_r0", ISS); check_step();

      // mid-operation reset
      ins(2, 3, 1, 1, 0, 0, 0); id_is_md = 1; id_md_div = 1;
      expect_all("rst_div", ISS); check_step();
      ins(0, 0, 1, 0, 1, 5, 1); expect_all("rst_lw", ISSB); check_step();
      ins(5, 0, 1, 1, 1, 6, 0); id_uses_hilo = 1; rst = 1;
      expect_all("mid_reset", RST); check_step();
      rst = 0;
      expect_all("post_reset", ISS); check_step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
